// File: rtl/macc_pkg.sv
// Shared definitions for the MAC sequencer and the datapath registers it steers.
package macc_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Operand-register select codes
  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_LOAD  = 2'b01;
  localparam logic [1:0] SEL_SHIFT = 2'b10;

  // Requested tap count clamped to the tap capacity of the datapath
  function automatic logic [3:0] clamp_len(input logic [3:0] len_i, input logic [3:0] max_i);
    return (len_i > max_i) ? max_i : len_i;
  endfunction

endpackage

// File: rtl/macc_seq_cnt.sv
// 4-bit loadable up-counter with terminal-count flag, used to pace the
// SHIFT (tap) and DRAIN (pipeline flush) phases.
module macc_seq_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  input  logic [3:0] term,
  output logic [3:0] cnt,
  output logic       tc
);

  logic [3:0] cnt_r;

  // Count register: clear has priority over load, load over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 4'd0;
    end else if (clr) begin
      cnt_r <= 4'd0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en) begin
      cnt_r <= cnt_r + 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;
  assign tc  = (cnt_r == term);

endmodule

// File: rtl/macc_seq_ctrl.sv
// Sequencer for a multiply-accumulate datapath: waits for an operand sample,
// clears the accumulator, steps through the taps, drains the pipeline and
// pulses done. All outputs decode from registered state; only din_valid
// reaches sel/acc_clr combinationally, and only while waiting in LOAD.
module macc_seq_ctrl
  import macc_pkg::*;
#(
  parameter int NTAP = 8,
  parameter int PIPE = 2
) (
  input  logic       CLK,
  input  logic       RST_L,
  input  logic       start,
  input  logic [3:0] len,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [1:0] sel,
  output logic       acc_clr,
  output logic       acc_en,
  output logic [3:0] tap_idx,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] NTAP_MAX  = 4'(NTAP);
  localparam logic [3:0] PIPE_LAST = 4'(PIPE - 1);

  state_e     state_r, state_s;
  logic [3:0] eff_len_r, eff_len_s;
  logic [3:0] tap_hold_r;
  logic [3:0] cnt_s, term_s;
  logic       cnt_clr_s, cnt_load_s, cnt_en_s, cnt_tc_s;

  // One counter paces both phases; its terminal value switches with the phase
  macc_seq_cnt u_cnt (
    .clk      (CLK),
    .rst_n    (RST_L),
    .clr      (cnt_clr_s),
    .load     (cnt_load_s),
    .load_val (4'd0),
    .en       (cnt_en_s),
    .term     (term_s),
    .cnt      (cnt_s),
    .tc       (cnt_tc_s)
  );

  // State and latched effective length
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      state_r   <= ST_IDLE;
      eff_len_r <= 4'd0;
    end else begin
      state_r   <= state_s;
      eff_len_r <= eff_len_s;
    end
  end

  // Keep the last tap index visible after SHIFT while the counter paces DRAIN
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      tap_hold_r <= 4'd0;
    end else if (state_r == ST_IDLE) begin
      tap_hold_r <= 4'd0;
    end else if (state_r == ST_SHIFT) begin
      tap_hold_r <= cnt_s;
    end else begin
      tap_hold_r <= tap_hold_r;
    end
  end

  // Next-state, counter control and output decode
  always_comb begin
    state_s    = state_r;
    eff_len_s  = eff_len_r;
    cnt_clr_s  = 1'b0;
    cnt_load_s = 1'b0;
    cnt_en_s   = 1'b0;
    term_s     = PIPE_LAST;
    din_ready  = 1'b0;
    sel        = SEL_HOLD;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    tap_idx    = tap_hold_r;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy      = 1'b0;
        tap_idx   = 4'd0;
        cnt_clr_s = 1'b1;
        if (start) begin
          eff_len_s = clamp_len(len, NTAP_MAX);
          if (eff_len_s != 4'd0) begin
            state_s = ST_LOAD;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        din_ready = 1'b1;
        if (din_valid) begin
          sel        = SEL_LOAD;
          acc_clr    = 1'b1;
          cnt_load_s = 1'b1;
          state_s    = ST_SHIFT;
        end else begin
          sel     = SEL_HOLD;
          state_s = ST_LOAD;
        end
      end
      ST_SHIFT: begin
        sel     = SEL_SHIFT;
        acc_en  = 1'b1;
        tap_idx = cnt_s;
        term_s  = eff_len_r - 4'd1;
        if (cnt_tc_s) begin
          cnt_load_s = 1'b1;
          state_s    = ST_DRAIN;
        end else begin
          cnt_en_s = 1'b1;
          state_s  = ST_SHIFT;
        end
      end
      ST_DRAIN: begin
        if (cnt_tc_s) begin
          state_s = ST_DONE;
        end else begin
          cnt_en_s = 1'b1;
          state_s  = ST_DRAIN;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_macc_seq_ctrl.sv
// Scoreboard bench for macc_seq_ctrl: accepted starts push the expected
// operation (effective length, start cycle); a monitor pops on every done
// pulse and also checks the per-cycle output invariants.
module tb_macc_seq_ctrl;

  localparam int NTAP = 8;
  localparam int PIPE = 2;

  logic       CLK, RST_L, start, din_valid;
  logic [3:0] len;
  logic       din_ready, acc_clr, acc_en, busy, done;
  logic [1:0] sel;
  logic [3:0] tap_idx;

  typedef struct {
    int eff;
    int start_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   model_idle = 1'b1;
  bit   done_pend = 1'b0;
  int   ob_clr = 0;
  int   ob_en = 0;
  int   ob_clr_cyc = 0;
  logic done_prev = 1'b0;

  macc_seq_ctrl #(.NTAP(NTAP), .PIPE(PIPE)) dut (
    .CLK       (CLK),
    .RST_L     (RST_L),
    .start     (start),
    .len       (len),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .sel       (sel),
    .acc_clr   (acc_clr),
    .acc_en    (acc_en),
    .tap_idx   (tap_idx),
    .busy      (busy),
    .done      (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int ref_eff(input int l);
    return (l > NTAP) ? NTAP : l;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_sel"},       int'(sel), 0);
    chk({tag, "_din_ready"}, int'(din_ready), 0);
    chk({tag, "_acc_clr"},   int'(acc_clr), 0);
    chk({tag, "_acc_en"},    int'(acc_en), 0);
    chk({tag, "_busy"},      int'(busy), 0);
    chk({tag, "_done"},      int'(done), 0);
    chk({tag, "_tap_idx"},   int'(tap_idx), 0);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (!model_idle && n < budget) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk({tag, "_reach_idle"}, int'(model_idle), 1);
  endtask

  // Reference model of acceptance: a start counts only while the controller is idle
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK or negedge RST_L);
      if (!RST_L) begin
        model_idle = 1'b1;
        done_pend  = 1'b0;
        exp_q.delete();
      end else begin
        if (model_idle && start) begin
          e.eff       = ref_eff(int'(len));
          e.start_cyc = cyc;
          exp_q.push_back(e);
          model_idle = 1'b0;
        end else if (done_pend) begin
          model_idle = 1'b1;
          done_pend  = 1'b0;
        end
        cyc++;
      end
    end
  end

  // Monitor: per-cycle invariants and scoreboard pop on each done pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK or negedge RST_L);
      if (!RST_L) begin
        ob_clr    = 0;
        ob_en     = 0;
        done_prev = 1'b0;
        done_pend = 1'b0;
      end else begin
        chk("sel_not_11",     int'(sel == 2'b11), 0);
        chk("clr_en_excl",    int'(acc_clr && acc_en), 0);
        chk("done_width",     int'(done && done_prev), 0);
        chk("busy_vs_model",  int'(busy), int'(!model_idle));
        chk("ready_when_idle", int'(din_ready && !busy), 0);
        chk("sel_load_is_clr", int'(sel == 2'b01), int'(acc_clr));
        chk("sel_shift_is_en", int'(sel == 2'b10), int'(acc_en));
        if (!busy) chk("idle_tap_idx", int'(tap_idx), 0);
        if (acc_clr) begin
          chk("clr_handshake", int'(din_ready && din_valid), 1);
          ob_clr++;
          ob_clr_cyc = cyc;
        end
        if (acc_en) begin
          chk("tap_idx_seq", int'(tap_idx), ob_en);
          ob_en++;
        end
        if (done) begin
          if (exp_q.size() == 0) begin
            chk("done_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("acc_en_count",  ob_en, e.eff);
            chk("acc_clr_count", ob_clr, (e.eff > 0) ? 1 : 0);
            if (e.eff > 0) chk("latency_from_load", cyc - ob_clr_cyc, e.eff + PIPE + 1);
            else           chk("latency_zero_len", cyc - e.start_cyc, 1);
          end
          done_pend = 1'b1;
          ob_clr    = 0;
          ob_en     = 0;
        end
        done_prev = done;
      end
    end
  end

  // Directed scenarios followed by randomized traffic
  initial begin
    bit seen;
    RST_L     = 1'b0;
    start     = 1'b0;
    len       = 4'd0;
    din_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_vals("por");

    // Nominal len=4, start present on the first edge after reset release
    RST_L = 1'b1; start = 1'b1; len = 4'd4; din_valid = 1'b1;
    @(posedge CLK); #1; start = 1'b0;
    wait_idle(100, "nominal");

    // Handshake stall
    start = 1'b1; len = 4'd3; din_valid = 1'b0;
    @(posedge CLK); #1; start = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      chk("stall_ready", int'(din_ready), 1);
      chk("stall_sel",   int'(sel), 0);
      chk("stall_busy",  int'(busy), 1);
      @(posedge CLK); #1;
    end
    din_valid = 1'b1;
    wait_idle(100, "stall");

    // Boundaries: zero length and over-capacity length
    start = 1'b1; len = 4'd0;
    @(posedge CLK); #1; start = 1'b0;
    wait_idle(100, "len0");
    start = 1'b1; len = 4'd12;
    @(posedge CLK); #1; start = 1'b0;
    wait_idle(100, "len12");

    // Start held through a whole operation
    start = 1'b1; len = 4'd2; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk("held_start_done_seen", int'(seen), 1);
    wait_idle(100, "held_start");
    repeat (4) @(posedge CLK);
    #1;

    // Asynchronous reset mid-SHIFT, then a single-tap operation
    start = 1'b1; len = 4'd8;
    @(posedge CLK); #1; start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (acc_en) break;
    end
    chk("mid_shift_reached", int'(acc_en), 1);
    @(negedge CLK);
    #2; RST_L = 1'b0;
    #1; check_reset_vals("async_rst");
    @(posedge CLK);
    #2; RST_L = 1'b1; start = 1'b1; len = 4'd1; din_valid = 1'b1;
    @(posedge CLK); #1; start = 1'b0;
    wait_idle(100, "after_rst");

    // Random traffic with occasional mid-cycle reset pulses
    for (int i = 0; i < 10000; i++) begin
      @(posedge CLK); #1;
      start     = ($urandom_range(0, 3) == 0);
      len       = 4'($urandom_range(0, 15));
      din_valid = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1999) == 0) begin
        #2; RST_L = 1'b0;
        #1; check_reset_vals("rnd_rst");
        RST_L = 1'b1;
      end
    end
    start = 1'b0; din_valid = 1'b1;
    wait_idle(200, "final");
    repeat (2) @(posedge CLK);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
